// File: rtl/fp_pkg.sv
// Shared field widths, constants and encodings for the single-precision
// normalise-and-round stage.
package fp_pkg;

  localparam int EXP_W      = 8;
  localparam int FRAC_W     = 23;
  localparam int EXT_MANT_W = 28;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  localparam logic [1:0] SPECIAL_NORMAL = 2'b00;
  localparam logic [1:0] SPECIAL_INF    = 2'b01;
  localparam logic [1:0] SPECIAL_NAN    = 2'b10;
  localparam logic [1:0] SPECIAL_RSVD   = 2'b11;

  localparam int FLAG_OVERFLOW  = 3;
  localparam int FLAG_UNDERFLOW = 2;
  localparam int FLAG_INEXACT   = 1;
  localparam int FLAG_ZERO      = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } state_t;

  function automatic logic [31:0] pack_fp(input logic sign,
                                          input logic [EXP_W-1:0] exp,
                                          input logic [FRAC_W-1:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/fp_norm_round_if.sv
// Operand/result handshake bundle between the FP adder and the
// normalise-and-round stage.
interface fp_norm_round_if;
  import fp_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_sign;
  logic [8:0]            in_exp;
  logic [EXT_MANT_W-1:0] in_mant;
  logic [1:0]            in_special;

  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out;
  logic [3:0]            out_flags;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_special, out_ready,
    input  in_ready, out_valid, out, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_special, out_ready,
    output in_ready, out_valid, out, out_flags
  );

endinterface

// File: rtl/fp_lzc28.sv
// Leading-zero counter over the hidden bit and below of the extended mantissa;
// an all-zero input yields 27.
module fp_lzc28 (
  input  logic [26:0] value,
  output logic [4:0]  count
);

  logic found;

  always_comb begin
    count = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && value[i]) begin
        count = 5'(26 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_norm_round.sv
// Post-adder normalise-and-round stage: iterative left normaliser followed by
// round-to-nearest-even, one operand in flight behind a valid/ready handshake.
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input logic            clk,
  input logic            rst_n,
  fp_norm_round_if.slave bus
);

  state_t state, state_next;

  logic                  sign_q, sign_next;
  logic [1:0]            special_q, special_next;
  logic signed [9:0]     exp_q, exp_next;
  logic [EXT_MANT_W-1:0] mant_q, mant_next;
  logic [31:0]           out_q, out_next;
  logic [3:0]            flags_q, flags_next;

  logic [4:0]        lz;
  logic [4:0]        shift_k;
  logic signed [9:0] exp_m1;

  logic norm_special, norm_zero, norm_carry, norm_hidden, norm_flush;

  logic              round_inc, round_inexact, round_ovf;
  logic [24:0]       round_sum;
  logic signed [9:0] round_exp;
  logic              unused_hidden;

  fp_lzc28 u_lzc (
    .value (mant_q[26:0]),
    .count (lz)
  );

  assign norm_special = (special_q != SPECIAL_NORMAL);
  assign norm_zero    = (mant_q == '0);
  assign norm_carry   = mant_q[27];
  assign norm_hidden  = mant_q[26];
  assign norm_flush   = (exp_q <= 10'sd1);

  // Round-to-nearest-even on the 24-bit significand; a carry out of the
  // significand leaves the lower bits zero, so the fraction needs no fix-up.
  assign round_inc     = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
  assign round_inexact = |mant_q[2:0];
  assign round_sum     = {1'b0, mant_q[26:3]} + 25'(round_inc);
  assign round_exp     = round_sum[24] ? (exp_q + 10'sd1) : exp_q;
  assign round_ovf     = (round_exp >= 10'(EXP_MAX));
  assign unused_hidden = round_sum[23];

  // Left-shift amount never drives the exponent below 1, so a value that
  // cannot be fully normalised falls through to the flush decision.
  assign exp_m1 = exp_q - 10'sd1;

  always_comb begin
    shift_k = lz;
    if (5'(SHIFT_STEP) < shift_k) shift_k = 5'(SHIFT_STEP);
    if (exp_m1 < $signed({5'd0, shift_k})) shift_k = exp_m1[4:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (bus.in_valid) state_next = ST_NORM;
      ST_NORM: begin
        if (norm_special || norm_zero)       state_next = ST_DONE;
        else if (norm_carry || norm_hidden)  state_next = ST_ROUND;
        else if (norm_flush)                 state_next = ST_DONE;
      end
      ST_ROUND: state_next = ST_DONE;
      ST_DONE:  if (bus.out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == ST_IDLE);
    bus.out_valid = (state == ST_DONE);
    bus.out       = out_q;
    bus.out_flags = flags_q;
  end

  // Result registers only change on the cycle that decides the result, so
  // they stay stable through DONE and after the transfer.
  always_comb begin
    sign_next    = sign_q;
    special_next = special_q;
    exp_next     = exp_q;
    mant_next    = mant_q;
    out_next     = out_q;
    flags_next   = flags_q;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          sign_next    = bus.in_sign;
          special_next = bus.in_special;
          exp_next     = $signed({1'b0, bus.in_exp});
          mant_next    = bus.in_mant;
        end
      end
      ST_NORM: begin
        if (norm_special) begin
          out_next   = (special_q == SPECIAL_INF) ? {sign_q, POS_INF[30:0]} : QNAN;
          flags_next = '0;
        end else if (norm_zero) begin
          out_next              = {sign_q, 31'h0};
          flags_next            = '0;
          flags_next[FLAG_ZERO] = 1'b1;
        end else if (norm_carry) begin
          mant_next = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
          exp_next  = exp_q + 10'sd1;
        end else if (norm_hidden) begin
          mant_next = mant_q;
        end else if (norm_flush) begin
          out_next                   = {sign_q, 31'h0};
          flags_next                 = '0;
          flags_next[FLAG_UNDERFLOW] = 1'b1;
          flags_next[FLAG_INEXACT]   = 1'b1;
          flags_next[FLAG_ZERO]      = 1'b1;
        end else begin
          mant_next = mant_q << shift_k;
          exp_next  = exp_q - $signed({5'd0, shift_k});
        end
      end
      ST_ROUND: begin
        flags_next = '0;
        if (round_ovf) begin
          out_next                  = {sign_q, POS_INF[30:0]};
          flags_next[FLAG_OVERFLOW] = 1'b1;
          flags_next[FLAG_INEXACT]  = 1'b1;
        end else begin
          out_next                 = pack_fp(sign_q, round_exp[7:0], round_sum[22:0]);
          flags_next[FLAG_INEXACT] = round_inexact;
        end
      end
      default: begin
        out_next = out_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q    <= 1'b0;
      special_q <= SPECIAL_NORMAL;
      exp_q     <= '0;
      mant_q    <= '0;
      out_q     <= '0;
      flags_q   <= '0;
    end else begin
      sign_q    <= sign_next;
      special_q <= special_next;
      exp_q     <= exp_next;
      mant_q    <= mant_next;
      out_q     <= out_next;
      flags_q   <= flags_next;
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// Scoreboard bench for fp_norm_round; two instances (SHIFT_STEP 1 and 4) run
// the same operands in lockstep so both latencies are checked per vector.
module tb_fp_norm_round;

  typedef struct {
    logic        sign;
    logic [8:0]  exp;
    logic [27:0] mant;
    logic [1:0]  special;
    logic [31:0] out;
    logic [3:0]  flags;
    int          lat1;
    int          lat4;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  vec_t sb[$];

  fp_norm_round_if bus ();
  fp_norm_round_if bus4 ();

  assign bus4.in_valid   = bus.in_valid;
  assign bus4.in_sign    = bus.in_sign;
  assign bus4.in_exp     = bus.in_exp;
  assign bus4.in_mant    = bus.in_mant;
  assign bus4.in_special = bus.in_special;
  assign bus4.out_ready  = bus.out_ready;

  fp_norm_round #(.SHIFT_STEP(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus));
  fp_norm_round #(.SHIFT_STEP(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Present one operand for one accept edge and record its expectation.
  task automatic apply_stimulus(input vec_t v);
    sb.push_back(v);
    bus.in_sign    = v.sign;
    bus.in_exp     = v.exp;
    bus.in_mant    = v.mant;
    bus.in_special = v.special;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
  endtask

  // Latency counts the accept edge as 1; a timeout leaves latency at 0.
  task automatic collect_result(output logic [31:0] o1, output logic [3:0] f1, output int l1,
                                output logic [31:0] o4, output logic [3:0] f4, output int l4);
    int cyc;
    cyc = 1;
    l1 = 0;
    l4 = 0;
    while ((l1 == 0 || l4 == 0) && cyc < 200) begin
      if (l1 == 0 && bus.out_valid === 1'b1) l1 = cyc;
      if (l4 == 0 && bus4.out_valid === 1'b1) l4 = cyc;
      if (l1 == 0 || l4 == 0) begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    o1 = bus.out;
    f1 = bus.out_flags;
    o4 = bus4.out;
    f4 = bus4.out_flags;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.out !== 32'h0) begin n_fail++; $display("[TB] FAIL reset out: got %h, want 00000000", bus.out); end
    n_checks++; if (bus.out_flags !== 4'h0) begin n_fail++; $display("[TB] FAIL reset flags: got %h, want 0", bus.out_flags); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset out_valid: got %b, want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset in_ready: got %b, want 1", bus.in_ready); end
    n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset out_valid(step4): got %b, want 0", bus4.out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL idle in_ready: got %b, want 1", bus.in_ready); end
  endtask

  task automatic test_normalise();
    vec_t vecs[4];
    vec_t e;
    logic [31:0] o1, o4;
    logic [3:0]  f1, f4;
    int          l1, l4;
    vecs[0] = '{1'b0, 9'd127, 28'h4000000, 2'b00, 32'h3F800000, 4'h0, 3, 3};
    vecs[1] = '{1'b0, 9'd127, 28'h8000000, 2'b00, 32'h40000000, 4'h0, 3, 3};
    vecs[2] = '{1'b0, 9'd130, 28'h0800000, 2'b00, 32'h3F800000, 4'h0, 6, 4};
    vecs[3] = '{1'b1, 9'd140, 28'h0000010, 2'b00, 32'hBB000000, 4'h0, 25, 9};
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      collect_result(o1, f1, l1, o4, f4, l4);
      e = sb.pop_front();
      n_checks++; if (o1 !== e.out) begin n_fail++; $display("[TB] FAIL norm[%0d] out(step1): got %h, want %h", i, o1, e.out); end
      n_checks++; if (f1 !== e.flags) begin n_fail++; $display("[TB] FAIL norm[%0d] flags(step1): got %h, want %h", i, f1, e.flags); end
      n_checks++; if (l1 !== e.lat1) begin n_fail++; $display("[TB] FAIL norm[%0d] latency(step1): got %0d, want %0d", i, l1, e.lat1); end
      n_checks++; if (o4 !== e.out) begin n_fail++; $display("[TB] FAIL norm[%0d] out(step4): got %h, want %h", i, o4, e.out); end
      n_checks++; if (f4 !== e.flags) begin n_fail++; $display("[TB] FAIL norm[%0d] flags(step4): got %h, want %h", i, f4, e.flags); end
      n_checks++; if (l4 !== e.lat4) begin n_fail++; $display("[TB] FAIL norm[%0d] latency(step4): got %0d, want %0d", i, l4, e.lat4); end
    end
  endtask

  task automatic test_rounding();
    vec_t vecs[7];
    vec_t e;
    logic [31:0] o1, o4;
    logic [3:0]  f1, f4;
    int          l1, l4;
    vecs[0] = '{1'b0, 9'd127, 28'h4000004, 2'b00, 32'h3F800000, 4'h2, 3, 3};
    vecs[1] = '{1'b0, 9'd127, 28'h400000C, 2'b00, 32'h3F800002, 4'h2, 3, 3};
    vecs[2] = '{1'b0, 9'd127, 28'h4000006, 2'b00, 32'h3F800001, 4'h2, 3, 3};
    vecs[3] = '{1'b0, 9'd127, 28'h7FFFFFC, 2'b00, 32'h40000000, 4'h2, 3, 3};
    vecs[4] = '{1'b0, 9'd254, 28'h7FFFFFC, 2'b00, 32'h7F800000, 4'hA, 3, 3};
    vecs[5] = '{1'b0, 9'd127, 28'h8000009, 2'b00, 32'h40000001, 4'h2, 3, 3};
    vecs[6] = '{1'b0, 9'd2,   28'h0100000, 2'b00, 32'h00000000, 4'h7, 3, 3};
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      collect_result(o1, f1, l1, o4, f4, l4);
      e = sb.pop_front();
      n_checks++; if (o1 !== e.out) begin n_fail++; $display("[TB] FAIL round[%0d] out(step1): got %h, want %h", i, o1, e.out); end
      n_checks++; if (f1 !== e.flags) begin n_fail++; $display("[TB] FAIL round[%0d] flags(step1): got %h, want %h", i, f1, e.flags); end
      n_checks++; if (l1 !== e.lat1) begin n_fail++; $display("[TB] FAIL round[%0d] latency(step1): got %0d, want %0d", i, l1, e.lat1); end
      n_checks++; if (o4 !== e.out) begin n_fail++; $display("[TB] FAIL round[%0d] out(step4): got %h, want %h", i, o4, e.out); end
      n_checks++; if (f4 !== e.flags) begin n_fail++; $display("[TB] FAIL round[%0d] flags(step4): got %h, want %h", i, f4, e.flags); end
      n_checks++; if (l4 !== e.lat4) begin n_fail++; $display("[TB] FAIL round[%0d] latency(step4): got %0d, want %0d", i, l4, e.lat4); end
    end
  endtask

  task automatic test_specials();
    vec_t vecs[5];
    vec_t e;
    logic [31:0] o1, o4;
    logic [3:0]  f1, f4;
    int          l1, l4;
    vecs[0] = '{1'b1, 9'd50,  28'h0000000, 2'b00, 32'h80000000, 4'h1, 2, 2};
    vecs[1] = '{1'b0, 9'd100, 28'h4000000, 2'b01, 32'h7F800000, 4'h0, 2, 2};
    vecs[2] = '{1'b1, 9'd100, 28'h4000000, 2'b01, 32'hFF800000, 4'h0, 2, 2};
    vecs[3] = '{1'b1, 9'd100, 28'h4000000, 2'b10, 32'h7FC00000, 4'h0, 2, 2};
    vecs[4] = '{1'b0, 9'd0,   28'h0000000, 2'b11, 32'h7FC00000, 4'h0, 2, 2};
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      collect_result(o1, f1, l1, o4, f4, l4);
      e = sb.pop_front();
      n_checks++; if (o1 !== e.out) begin n_fail++; $display("[TB] FAIL special[%0d] out(step1): got %h, want %h", i, o1, e.out); end
      n_checks++; if (f1 !== e.flags) begin n_fail++; $display("[TB] FAIL special[%0d] flags(step1): got %h, want %h", i, f1, e.flags); end
      n_checks++; if (l1 !== e.lat1) begin n_fail++; $display("[TB] FAIL special[%0d] latency(step1): got %0d, want %0d", i, l1, e.lat1); end
      n_checks++; if (o4 !== e.out) begin n_fail++; $display("[TB] FAIL special[%0d] out(step4): got %h, want %h", i, o4, e.out); end
      n_checks++; if (l4 !== e.lat4) begin n_fail++; $display("[TB] FAIL special[%0d] latency(step4): got %0d, want %0d", i, l4, e.lat4); end
    end
  endtask

  task automatic test_backpressure();
    vec_t v;
    vec_t e;
    int   cyc;
    v = '{1'b0, 9'd127, 28'h4000000, 2'b00, 32'h3F800000, 4'h0, 3, 3};
    apply_stimulus(v);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    e = sb.pop_front();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp out_valid: got %b, want 1", bus.out_valid); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      n_checks++; if (bus.out !== e.out) begin n_fail++; $display("[TB] FAIL bp[%0d] out: got %h, want %h", c, bus.out, e.out); end
      n_checks++; if (bus.out_flags !== e.flags) begin n_fail++; $display("[TB] FAIL bp[%0d] flags: got %h, want %h", c, bus.out_flags, e.flags); end
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp[%0d] out_valid: got %b, want 1", c, bus.out_valid); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp[%0d] in_ready: got %b, want 0", c, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp release out_valid: got %b, want 0", bus.out_valid); end
    n_checks++; if (bus.out !== e.out) begin n_fail++; $display("[TB] FAIL bp release out held: got %h, want %h", bus.out, e.out); end
  endtask

  task automatic test_back_to_back();
    vec_t a, b, e;
    logic [31:0] o1, o4;
    logic [3:0]  f1, f4;
    int          l1, l4;
    a = '{1'b0, 9'd127, 28'h4000000, 2'b00, 32'h3F800000, 4'h0, 3, 3};
    b = '{1'b1, 9'd128, 28'h8000000, 2'b00, 32'hC0800000, 4'h0, 3, 3};
    apply_stimulus(a);
    collect_result(o1, f1, l1, o4, f4, l4);
    e = sb.pop_front();
    n_checks++; if (o1 !== e.out) begin n_fail++; $display("[TB] FAIL b2b first out: got %h, want %h", o1, e.out); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b in_ready after transfer: got %b, want 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b out_valid after transfer: got %b, want 0", bus.out_valid); end
    apply_stimulus(b);
    collect_result(o1, f1, l1, o4, f4, l4);
    e = sb.pop_front();
    n_checks++; if (o1 !== e.out) begin n_fail++; $display("[TB] FAIL b2b second out: got %h, want %h", o1, e.out); end
    n_checks++; if (l1 !== e.lat1) begin n_fail++; $display("[TB] FAIL b2b second latency: got %0d, want %0d", l1, e.lat1); end
    n_checks++; if (o4 !== e.out) begin n_fail++; $display("[TB] FAIL b2b second out(step4): got %h, want %h", o4, e.out); end
  endtask

  task automatic test_reset_in_norm();
    vec_t v, e;
    logic [31:0] o1, o4;
    logic [3:0]  f1, f4;
    int          l1, l4;
    int          stale;
    bus.in_sign    = 1'b0;
    bus.in_exp     = 9'd140;
    bus.in_mant    = 28'h0000001;
    bus.in_special = 2'b00;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_norm busy in_ready: got %b, want 0", bus.in_ready); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_norm out_valid: got %b, want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_norm in_ready: got %b, want 1", bus.in_ready); end
    n_checks++; if (bus4.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_norm in_ready(step4): got %b, want 1", bus4.in_ready); end
    n_checks++; if (bus.out !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_norm out: got %h, want 00000000", bus.out); end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1 || bus4.out_valid === 1'b1) stale++;
    end
    n_checks++; if (stale !== 0) begin n_fail++; $display("[TB] FAIL rst_norm stale result cycles: got %0d, want 0", stale); end
    v = '{1'b0, 9'd127, 28'h8000000, 2'b00, 32'h40000000, 4'h0, 3, 3};
    apply_stimulus(v);
    collect_result(o1, f1, l1, o4, f4, l4);
    e = sb.pop_front();
    n_checks++; if (o1 !== e.out) begin n_fail++; $display("[TB] FAIL rst_norm recovery out: got %h, want %h", o1, e.out); end
    n_checks++; if (l1 !== e.lat1) begin n_fail++; $display("[TB] FAIL rst_norm recovery latency: got %0d, want %0d", l1, e.lat1); end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_n          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_sign    = 1'b0;
    bus.in_exp     = '0;
    bus.in_mant    = '0;
    bus.in_special = 2'b00;
    bus.out_ready  = 1'b0;
    test_reset();
    test_normalise();
    test_rounding();
    test_specials();
    test_backpressure();
    test_back_to_back();
    test_reset_in_norm();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
- Post-adder normalise-and-round stage for IEEE-754 single precision; sits directly downstream of the FP adder datapath.
- Input: the adder's raw sum as sign, biased exponent and a 28-bit extended mantissa (carry, hidden bit, fraction, guard/round/sticky).
- Normalises the sum with an iterative multi-cycle left shifter, then rounds to nearest-even.
- Emits the packed 32-bit result plus exception flags over a valid/ready handshake.

Parameters:
SHIFT_STEP, 1, maximum left-shift bits applied per NORM cycle (legal 1..4)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input operand valid
in_ready  output  1  stage can accept; high only in IDLE
in_sign  input  1  sign of raw sum
in_exp  input  9  biased exponent of raw sum (0..511)
in_mant  input  28  [27]=carry, [26]=hidden, [25:3]=fraction, [2]=guard, [1]=round, [0]=sticky
in_special  input  2  00 normal, 01 infinity, 10 NaN, 11 reserved (treated as NaN)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out  output  32  packed IEEE-754 result
out_flags  output  4  [3]=overflow, [2]=underflow, [1]=inexact, [0]=zero

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out=32'h0, out_flags=4'h0, out_valid=0, internal registers cleared. Any in-flight operand is dropped; no output is produced for it.
- Handshake: accept on a rising edge with in_valid&&in_ready. Output transfers on a rising edge with out_valid&&out_ready.
- out and out_flags stay stable while out_valid=1.
- in_ready is combinational from state only (IDLE=1).
- Internal exponent: 10-bit signed. Mantissa register: 28 bits.
- IDLE: on accept, latch all inputs and go to NORM.
  - in_special=01: go directly to DONE with out={sign,8'hFF,23'h0}, flags 0.
  - in_special=1x: go directly to DONE with out=32'h7FC00000, flags 0.
- NORM: priority order, one decision per cycle:
  1. mant==0: out={sign,31'h0}, zero=1, go to DONE.
  2. mant[27]=1: shift right 1, mant[0] |= dropped bit, exp+1, go to ROUND.
  3. mant[26]=1: go to ROUND.
  4. exp<=1: flush. out={sign,31'h0}, underflow=1, inexact=1, zero=1, go to DONE.
  5. Otherwise: shift left by k=min(SHIFT_STEP, leading zeros above bit 26, exp-1); exp-=k; stay in NORM.
- ROUND (RNE): lsb=mant[3], g=mant[2], r=mant[1], s=mant[0].
  - inc = g&(r|s|lsb). inexact = g|r|s.
  - Form the 25-bit sum mant[26:3]+inc. If it carries out, exp+1 and fraction=0.
  - If exp>=255: out={sign,8'hFF,23'h0}, overflow=1, inexact=1.
  - Else: out={sign,exp[7:0],fraction}.
  - Go to DONE.
- DONE: out_valid=1. On out_ready, clear out_valid and go to IDLE. out and out_flags keep their last value after the transfer.
- Latency, counted in rising edges after the accept edge until out_valid is high:
  - specials and zero: 2
  - normalised or carry input: 3
  - plus ceil(lz/SHIFT_STEP) for left-normalised input
- Throughput: one operand in flight. A new accept can occur on the edge after the output transfer, not the same edge.
- Backpressure: out_ready=0 holds DONE indefinitely, with in_ready=0.
- rst_n asserted in any state returns to IDLE immediately, independent of clk.

Decomposition:
- Shared package fp_pkg:
  - field widths: EXP_W=8, FRAC_W=23, EXT_MANT_W=28
  - BIAS=127, EXP_MAX=255
  - constants QNAN=32'h7FC00000, POS_INF=32'h7F800000
  - in_special encodings
  - out_flags bit indices
- One sub-module, fp_lzc28: combinational leading-zero counter over in_mant[26:0], 5-bit count. Used by NORM to compute k.
- FSM and rounding stay in the top module.

Test Plan:
- Normalised input: sign=0, exp=127, mant=28'h4000000 -> out=3F800000, flags=0, out_valid 3 edges after accept.
- Carry input: exp=127, mant=28'h8000000 -> out=40000000, flags=0, latency 3.
- Left shift with SHIFT_STEP=1: exp=130, mant=28'h0800000 (lz=3) -> out=3F800000, latency 6. Repeat with SHIFT_STEP=4 -> latency 4.
- Rounding:
  - tie to even, mant=28'h4000004 -> out=3F800000, inexact=1
  - tie with odd lsb, mant=28'h400000C -> out=3F800002, inexact=1
- Overflow: exp=254, mant=28'h7FFFFFC -> rounding carry, out=7F800000, overflow=1, inexact=1.
- Control cases:
  - mant=0, sign=1 -> out=80000000, zero=1, latency 2.
  - in_special=10 -> out=7FC00000.
  - hold out_ready=0 for 5 cycles -> out stable, in_ready=0.
  - assert rst_n=0 in NORM -> out_valid=0 and in_ready=1 immediately, no stale result.
